// File: rtl/log_spawn_scheduler_if.sv
// Spawn command channel between the log spawn scheduler and the lane/log
// object controllers: valid/ready command plus the one-cycle grant strobe.
interface log_spawn_scheduler_if #(
  parameter int NUM_OF_LOGS = 15,
  parameter int OFFSET_W    = 9,
  parameter int NUM_LANES   = 5
);
  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int IDX_W  = $clog2(NUM_OF_LOGS);

  logic                 spawn_valid;
  logic                 spawn_ready;
  logic [LANE_W-1:0]    spawn_lane;
  logic [IDX_W-1:0]     spawn_idx;
  logic [OFFSET_W-1:0]  spawn_offsetX;
  logic [OFFSET_W-1:0]  spawn_offsetY;
  logic [NUM_LANES-1:0] grant_pulse;

  modport master (
    output spawn_valid, spawn_lane, spawn_idx, spawn_offsetX, spawn_offsetY,
           grant_pulse,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid, spawn_lane, spawn_idx, spawn_offsetX, spawn_offsetY,
           grant_pulse,
    output spawn_ready
  );
endinterface

// File: rtl/log_spawn_scheduler.sv
// Log spawn scheduler: once per frame, picks a river lane that needs a new
// log (round-robin, honouring a per-lane cooldown) and issues one spawn
// command carrying the next entry of the random X/Y offset table.
module log_spawn_scheduler #(
  parameter int NUM_OF_LOGS = 15,
  parameter int OFFSET_W    = 9,
  parameter int NUM_LANES   = 5,
  parameter int SPAWN_GAP   = 8
) (
  input  logic                                CLK,
  input  logic                                resetN,
  input  logic                                startOfFrame,
  input  logic [NUM_LANES-1:0]                respawn_req,
  input  logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0] table_offsetX,
  input  logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0] table_offsetY,
  log_spawn_scheduler_if.master               spawn_if
);
  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int IDX_W  = $clog2(NUM_OF_LOGS);
  localparam int CD_W   = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
  localparam int unsigned NL = NUM_LANES;

  localparam logic [CD_W-1:0]   GAP_LOAD   = CD_W'(SPAWN_GAP);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_OF_LOGS - 1);
  localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(NUM_LANES - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]           state;
  logic [IDX_W-1:0]     idx;
  logic [LANE_W-1:0]    last_grant;
  logic [CD_W-1:0]      cooldown [NUM_LANES];
  logic [NUM_LANES-1:0] eligible;
  logic                 pick_found;
  logic [LANE_W-1:0]    pick_lane;
  logic                 handshake;

  assign handshake            = (state == ISSUE) && spawn_if.spawn_ready;
  assign spawn_if.spawn_valid = (state == ISSUE);

  // A lane may be granted only while it requests and its cooldown has expired.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      eligible[i] = respawn_req[i] && (cooldown[i] == '0);
    end
  end

  // Round-robin pick: first eligible lane after last_grant, wrapping modulo NUM_LANES.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_lane  = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NL; k++) begin
      cand = (32'(last_grant) + k) % NL;
      if (!pick_found && eligible[LANE_W'(cand)]) begin
        pick_found = 1'b1;
        pick_lane  = LANE_W'(cand);
      end
    end
  end

  // Grant strobe on the handshake cycle; a reset in the same cycle cancels it.
  always_comb begin
    spawn_if.grant_pulse = '0;
    if (handshake && resetN) begin
      spawn_if.grant_pulse[spawn_if.spawn_lane] = 1'b1;
    end
  end

  // Command FSM: capture lane/index/offsets at grant, hold them until accepted.
  always_ff @(posedge CLK) begin
    if (!resetN) begin
      state                  <= IDLE;
      idx                    <= '0;
      last_grant             <= LANE_LAST;
      spawn_if.spawn_lane    <= '0;
      spawn_if.spawn_idx     <= '0;
      spawn_if.spawn_offsetX <= '0;
      spawn_if.spawn_offsetY <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startOfFrame && pick_found) begin
            spawn_if.spawn_lane    <= pick_lane;
            spawn_if.spawn_idx     <= idx;
            spawn_if.spawn_offsetX <= table_offsetX[idx];
            spawn_if.spawn_offsetY <= table_offsetY[idx];
            state                  <= ISSUE;
          end
        end
        ISSUE: begin
          if (spawn_if.spawn_ready) begin
            last_grant <= spawn_if.spawn_lane;
            idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-lane cooldown: a grant reloads the gap (beating the per-frame decrement).
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NL; i++) begin
      if (!resetN) begin
        cooldown[i] <= '0;
      end else if (handshake && (spawn_if.spawn_lane == LANE_W'(i))) begin
        cooldown[i] <= GAP_LOAD;
      end else if (startOfFrame && (cooldown[i] != '0)) begin
        cooldown[i] <= cooldown[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_log_spawn_scheduler.sv
// Scoreboard bench for log_spawn_scheduler: instance A has an 8-frame
// cooldown, instance B has none. Expected spawn commands are queued by the
// stimulus and checked by per-instance monitors on each handshake.
module tb_log_spawn_scheduler;
  typedef struct {
    int lane;
    int idx;
    int ox;
    int oy;
  } exp_t;

  logic CLK;
  logic resetN;
  logic sof;
  logic [4:0] req_a, req_b;
  logic [14:0][8:0] tx, ty;

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  log_spawn_scheduler_if #(.NUM_OF_LOGS(15), .OFFSET_W(9), .NUM_LANES(5)) ifa ();
  log_spawn_scheduler_if #(.NUM_OF_LOGS(15), .OFFSET_W(9), .NUM_LANES(5)) ifb ();

  log_spawn_scheduler #(.NUM_OF_LOGS(15), .OFFSET_W(9), .NUM_LANES(5), .SPAWN_GAP(8)) dut_a (
    .CLK(CLK), .resetN(resetN), .startOfFrame(sof), .respawn_req(req_a),
    .table_offsetX(tx), .table_offsetY(ty), .spawn_if(ifa.master)
  );

  log_spawn_scheduler #(.NUM_OF_LOGS(15), .OFFSET_W(9), .NUM_LANES(5), .SPAWN_GAP(0)) dut_b (
    .CLK(CLK), .resetN(resetN), .startOfFrame(sof), .respawn_req(req_b),
    .table_offsetX(tx), .table_offsetY(ty), .spawn_if(ifb.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_a(input int lane, input int idx);
    exp_t e;
    e.lane = lane; e.idx = idx; e.ox = int'(tx[idx]); e.oy = int'(ty[idx]);
    qa.push_back(e);
  endtask

  task automatic push_b(input int lane, input int idx);
    exp_t e;
    e.lane = lane; e.idx = idx; e.ox = int'(tx[idx]); e.oy = int'(ty[idx]);
    qb.push_back(e);
  endtask

  // One-cycle startOfFrame; returns 1 time unit after the edge that samples it.
  task automatic pulse();
    @(posedge CLK); #1 sof = 1'b1;
    @(posedge CLK); #1 sof = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor A: every handshake must match the head of the expected queue.
  always @(negedge CLK) begin
    if (resetN === 1'b1) begin
      if (ifa.spawn_valid === 1'b1 && ifa.spawn_ready === 1'b1) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_spawn actual lane=%0d idx=%0d expected none",
                   ifa.spawn_lane, ifa.spawn_idx);
        end else begin
          ea = qa.pop_front();
          chk("a_lane", 32'(ifa.spawn_lane), 32'(ea.lane));
          chk("a_idx", 32'(ifa.spawn_idx), 32'(ea.idx));
          chk("a_offx", 32'(ifa.spawn_offsetX), 32'(ea.ox));
          chk("a_offy", 32'(ifa.spawn_offsetY), 32'(ea.oy));
          chk("a_grant", 32'(ifa.grant_pulse), 32'(1) << ea.lane);
        end
      end else begin
        chk("a_grant_idle", 32'(ifa.grant_pulse), 32'(0));
      end
    end
  end

  // Monitor B: same checks for the no-cooldown instance.
  always @(negedge CLK) begin
    if (resetN === 1'b1) begin
      if (ifb.spawn_valid === 1'b1 && ifb.spawn_ready === 1'b1) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_spawn actual lane=%0d idx=%0d expected none",
                   ifb.spawn_lane, ifb.spawn_idx);
        end else begin
          eb = qb.pop_front();
          chk("b_lane", 32'(ifb.spawn_lane), 32'(eb.lane));
          chk("b_idx", 32'(ifb.spawn_idx), 32'(eb.idx));
          chk("b_offx", 32'(ifb.spawn_offsetX), 32'(eb.ox));
          chk("b_offy", 32'(ifb.spawn_offsetY), 32'(eb.oy));
          chk("b_grant", 32'(ifb.grant_pulse), 32'(1) << eb.lane);
        end
      end else begin
        chk("b_grant_idle", 32'(ifb.grant_pulse), 32'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int seq [3];
    seq[0] = 0; seq[1] = 1; seq[2] = 3;
    resetN = 1'b0;
    sof = 1'b0;
    req_a = '0;
    req_b = '0;
    ifa.spawn_ready = 1'b0;
    ifb.spawn_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tx[i] = 9'(i * 10 + 5);
      ty[i] = 9'(300 - i * 7);
    end

    // Reset: two cycles low, every output cleared.
    gap(2);
    chk("rst_a_valid", 32'(ifa.spawn_valid), 0);
    chk("rst_a_lane", 32'(ifa.spawn_lane), 0);
    chk("rst_a_idx", 32'(ifa.spawn_idx), 0);
    chk("rst_a_offx", 32'(ifa.spawn_offsetX), 0);
    chk("rst_a_offy", 32'(ifa.spawn_offsetY), 0);
    chk("rst_a_grant", 32'(ifa.grant_pulse), 0);
    chk("rst_b_valid", 32'(ifb.spawn_valid), 0);
    chk("rst_b_grant", 32'(ifb.grant_pulse), 0);
    resetN = 1'b1;
    gap(2);

    // First spawn: lane 2 alone, table entry 0, valid one cycle after the frame pulse.
    req_a = 5'b00100;
    ifa.spawn_ready = 1'b1;
    push_a(2, 0);
    pulse();
    chk("t1_latency_valid", 32'(ifa.spawn_valid), 1);
    gap(4);
    req_a = '0;

    // Cooldown: lane 1 spawns, is blocked for 8 frames, spawns again on the 9th.
    req_a = 5'b00010;
    push_a(1, 1);
    pulse();
    gap(4);
    for (int f = 0; f < 8; f++) begin
      pulse();
      chk("t3_cooldown_valid", 32'(ifa.spawn_valid), 0);
      gap(3);
    end
    push_a(1, 2);
    pulse();
    chk("t3_respawn_valid", 32'(ifa.spawn_valid), 1);
    gap(4);
    req_a = '0;

    // Backpressure: command held through 3 frames despite request/table changes.
    req_a = 5'b01000;
    ifa.spawn_ready = 1'b0;
    push_a(3, 3);
    pulse();
    tx[3] = 9'h1FF;
    ty[3] = 9'h000;
    req_a = '0;
    for (int f = 0; f < 3; f++) begin
      gap(3);
      pulse();
      chk("t4_hold_valid", 32'(ifa.spawn_valid), 1);
      chk("t4_hold_lane", 32'(ifa.spawn_lane), 3);
      chk("t4_hold_idx", 32'(ifa.spawn_idx), 3);
      chk("t4_hold_offx", 32'(ifa.spawn_offsetX), 35);
      chk("t4_hold_offy", 32'(ifa.spawn_offsetY), 279);
    end
    tx[3] = 9'(35);
    ty[3] = 9'(279);
    @(posedge CLK); #1 ifa.spawn_ready = 1'b1;
    gap(1);
    chk("t4_valid_drop", 32'(ifa.spawn_valid), 0);
    req_a = 5'b10000;
    push_a(4, 4);
    pulse();
    gap(4);
    req_a = '0;

    // Round-robin over lanes 0,1,3 with no cooldown; 16 spawns wrap the index 14 -> 0.
    req_b = 5'b01011;
    ifb.spawn_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      push_b(seq[k % 3], k % 15);
      pulse();
      gap(3);
    end

    // Reset while a command is pending: valid drops, index restarts at 0.
    ifb.spawn_ready = 1'b0;
    pulse();
    chk("t5_pending_valid", 32'(ifb.spawn_valid), 1);
    gap(2);
    resetN = 1'b0;
    gap(1);
    chk("t5_rst_b_valid", 32'(ifb.spawn_valid), 0);
    chk("t5_rst_b_grant", 32'(ifb.grant_pulse), 0);
    chk("t5_rst_a_valid", 32'(ifa.spawn_valid), 0);
    resetN = 1'b1;
    ifb.spawn_ready = 1'b1;
    push_b(0, 0);
    pulse();
    gap(4);
    req_b = '0;

    for (int i = 0; i < 50 && (qa.size() + qb.size()) != 0; i++) @(posedge CLK);
    #1;
    chk("queues_drained", 32'(qa.size() + qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
